// File: rtl/udp_rx_port_filter.sv
// UDP receive port filter: forwards header and payload of packets addressed to
// LOCAL_PORT with a legal length, and silently consumes everything else.
module udp_rx_port_filter #(
    parameter logic [15:0] LOCAL_PORT  = 16'd8080,
    parameter logic [15:0] MIN_UDP_LEN = 16'd8
) (
    input  logic         wClk,
    input  logic         wRst,
    input  logic         wData_Hdr_in_valid,
    output logic         wData_Hdr_in_ready,
    input  logic [31:0]  bData_Hdr_in_IPSrcIpAddr,
    input  logic [15:0]  bData_Hdr_in_UDPSrcPort,
    input  logic [15:0]  bData_Hdr_in_UDPDstPort,
    input  logic [15:0]  bData_Hdr_in_UDPLength,
    input  logic         wData_in_valid,
    output logic         wData_in_ready,
    input  logic [127:0] bData_in_data,
    input  logic [15:0]  bData_in_keep,
    input  logic         wData_in_last,
    output logic         wData_Hdr_out_valid,
    input  logic         wData_Hdr_out_ready,
    output logic [31:0]  bData_Hdr_out_IPSrcIpAddr,
    output logic [15:0]  bData_Hdr_out_UDPSrcPort,
    output logic [15:0]  bData_Hdr_out_UDPLength,
    output logic         wData_out_valid,
    input  logic         wData_out_ready,
    output logic [127:0] bData_out_data,
    output logic [15:0]  bData_out_keep,
    output logic         wData_out_last,
    output logic [31:0]  bPass_packet_cnt,
    output logic [31:0]  bDrop_packet_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HDR_OUT,
        PASS,
        DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic st_idle;
    logic st_hdr;
    logic st_pass;
    logic st_drop;
    logic hdr_in_fire;
    logic hdr_out_fire;
    logic data_in_fire;
    logic hdr_match;
    logic pass_done;
    logic drop_done;

    assign st_idle = (state == IDLE);
    assign st_hdr  = (state == HDR_OUT);
    assign st_pass = (state == PASS);
    assign st_drop = (state == DROP);

    // Header ready is gated by reset so it reads 0 while reset is held.
    assign wData_Hdr_in_ready  = st_idle && wRst;
    assign wData_in_ready      = (st_pass && wData_out_ready) || st_drop;
    assign wData_Hdr_out_valid = st_hdr;
    assign wData_out_valid     = st_pass && wData_in_valid;
    assign wData_out_last      = st_pass && wData_in_last;
    assign bData_out_data      = bData_in_data;
    assign bData_out_keep      = st_pass ? bData_in_keep : 16'd0;

    assign hdr_in_fire  = wData_Hdr_in_valid && wData_Hdr_in_ready;
    assign hdr_out_fire = st_hdr && wData_Hdr_out_ready;
    assign data_in_fire = wData_in_valid && wData_in_ready;
    assign hdr_match    = (bData_Hdr_in_UDPDstPort == LOCAL_PORT) &&
                          (bData_Hdr_in_UDPLength >= MIN_UDP_LEN);
    assign pass_done    = st_pass && data_in_fire && wData_in_last;
    assign drop_done    = st_drop && data_in_fire && wData_in_last;

    always_ff @(posedge wClk or negedge wRst) begin
        if (!wRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hdr_in_fire) begin
                    state_next = hdr_match ? HDR_OUT : DROP;
                end
            end
            HDR_OUT: begin
                if (hdr_out_fire) begin
                    state_next = PASS;
                end
            end
            PASS: begin
                if (pass_done) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (drop_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wClk or negedge wRst) begin
        if (!wRst) begin
            bData_Hdr_out_IPSrcIpAddr <= 32'd0;
            bData_Hdr_out_UDPSrcPort  <= 16'd0;
            bData_Hdr_out_UDPLength   <= 16'd0;
        end else if (hdr_in_fire) begin
            bData_Hdr_out_IPSrcIpAddr <= bData_Hdr_in_IPSrcIpAddr;
            bData_Hdr_out_UDPSrcPort  <= bData_Hdr_in_UDPSrcPort;
            bData_Hdr_out_UDPLength   <= bData_Hdr_in_UDPLength;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge wClk or negedge wRst) begin
        if (!wRst) begin
            bPass_packet_cnt <= 32'd0;
            bDrop_packet_cnt <= 32'd0;
        end else begin
            if (pass_done && (bPass_packet_cnt != 32'hFFFF_FFFF)) begin
                bPass_packet_cnt <= bPass_packet_cnt + 32'd1;
            end
            if (drop_done && (bDrop_packet_cnt != 32'hFFFF_FFFF)) begin
                bDrop_packet_cnt <= bDrop_packet_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// Scoreboard bench for udp_rx_port_filter: expected headers/beats are queued
// as stimulus is driven and popped when the DUT hands them downstream.
`timescale 1ns/1ps
module tb_udp_rx_port_filter;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] len;
    } hdr_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic         wClk = 1'b0;
    logic         wRst = 1'b0;
    logic         wData_Hdr_in_valid = 1'b0;
    logic         wData_Hdr_in_ready;
    logic [31:0]  bData_Hdr_in_IPSrcIpAddr = 32'd0;
    logic [15:0]  bData_Hdr_in_UDPSrcPort = 16'd0;
    logic [15:0]  bData_Hdr_in_UDPDstPort = 16'd0;
    logic [15:0]  bData_Hdr_in_UDPLength = 16'd0;
    logic         wData_in_valid = 1'b0;
    logic         wData_in_ready;
    logic [127:0] bData_in_data = '0;
    logic [15:0]  bData_in_keep = '0;
    logic         wData_in_last = 1'b0;
    logic         wData_Hdr_out_valid;
    logic         wData_Hdr_out_ready = 1'b1;
    logic [31:0]  bData_Hdr_out_IPSrcIpAddr;
    logic [15:0]  bData_Hdr_out_UDPSrcPort;
    logic [15:0]  bData_Hdr_out_UDPLength;
    logic         wData_out_valid;
    logic         wData_out_ready = 1'b1;
    logic [127:0] bData_out_data;
    logic [15:0]  bData_out_keep;
    logic         wData_out_last;
    logic [31:0]  bPass_packet_cnt;
    logic [31:0]  bDrop_packet_cnt;

    hdr_t        hdr_q[$];
    beat_t       beat_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pass = 0;
    logic [31:0] exp_drop = 0;
    bit          cur_pass = 1'b0;
    int          out_mode = 0;

    udp_rx_port_filter dut (
        .wClk(wClk), .wRst(wRst),
        .wData_Hdr_in_valid(wData_Hdr_in_valid), .wData_Hdr_in_ready(wData_Hdr_in_ready),
        .bData_Hdr_in_IPSrcIpAddr(bData_Hdr_in_IPSrcIpAddr),
        .bData_Hdr_in_UDPSrcPort(bData_Hdr_in_UDPSrcPort),
        .bData_Hdr_in_UDPDstPort(bData_Hdr_in_UDPDstPort),
        .bData_Hdr_in_UDPLength(bData_Hdr_in_UDPLength),
        .wData_in_valid(wData_in_valid), .wData_in_ready(wData_in_ready),
        .bData_in_data(bData_in_data), .bData_in_keep(bData_in_keep),
        .wData_in_last(wData_in_last),
        .wData_Hdr_out_valid(wData_Hdr_out_valid), .wData_Hdr_out_ready(wData_Hdr_out_ready),
        .bData_Hdr_out_IPSrcIpAddr(bData_Hdr_out_IPSrcIpAddr),
        .bData_Hdr_out_UDPSrcPort(bData_Hdr_out_UDPSrcPort),
        .bData_Hdr_out_UDPLength(bData_Hdr_out_UDPLength),
        .wData_out_valid(wData_out_valid), .wData_out_ready(wData_out_ready),
        .bData_out_data(bData_out_data), .bData_out_keep(bData_out_keep),
        .wData_out_last(wData_out_last),
        .bPass_packet_cnt(bPass_packet_cnt), .bDrop_packet_cnt(bDrop_packet_cnt)
    );

    always #5 wClk = ~wClk;

    // Downstream payload ready: mode 0 holds 1, mode 1 toggles each cycle.
    always @(posedge wClk) begin
        #1;
        if (out_mode == 1) wData_out_ready = ~wData_out_ready;
        else wData_out_ready = 1'b1;
    end

    task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sp,
                            input logic [15:0] dp, input logic [15:0] len);
        int waits = 0;
        cur_pass = (dp == 16'd8080) && (len >= 16'd8);
        if (cur_pass) hdr_q.push_back({ip, sp, len});
        wData_Hdr_in_valid = 1'b1;
        bData_Hdr_in_IPSrcIpAddr = ip;
        bData_Hdr_in_UDPSrcPort = sp;
        bData_Hdr_in_UDPDstPort = dp;
        bData_Hdr_in_UDPLength = len;
        @(negedge wClk);
        while (!wData_Hdr_in_ready && waits < 200) begin
            @(negedge wClk);
            waits++;
        end
        total++;
        if (wData_Hdr_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hdr_accept_timeout got ready=%b want 1", wData_Hdr_in_ready);
        end
        @(posedge wClk);
        #1;
        wData_Hdr_in_valid = 1'b0;
        bData_Hdr_in_UDPDstPort = 16'd0;
        @(negedge wClk);
        total++;
        if (wData_Hdr_out_valid !== cur_pass) begin
            bad++;
            $display("[TB] FAIL hdr_out_latency got valid=%b want %b", wData_Hdr_out_valid, cur_pass);
        end
        @(posedge wClk);
        #1;
    endtask

    task automatic send_beat(input logic [127:0] data, input logic [15:0] keep,
                             input logic last, output int waits);
        waits = 0;
        if (cur_pass) beat_q.push_back({data, keep, last});
        wData_in_valid = 1'b1;
        bData_in_data = data;
        bData_in_keep = keep;
        wData_in_last = last;
        @(negedge wClk);
        while (1) begin
            total++;
            if (wData_Hdr_in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hdr_in_ready_busy got %b want 0", wData_Hdr_in_ready);
            end
            if (!cur_pass) begin
                total++;
                if (wData_out_valid !== 1'b0 || wData_Hdr_out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL drop_leak got out_valid=%b hdr_valid=%b want 0 0",
                             wData_out_valid, wData_Hdr_out_valid);
                end
            end
            if (wData_in_ready === 1'b1 || waits >= 200) break;
            @(negedge wClk);
            waits++;
        end
        total++;
        if (wData_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL beat_accept_timeout got ready=%b want 1", wData_in_ready);
        end
        @(posedge wClk);
        #1;
        wData_in_valid = 1'b0;
        wData_in_last = 1'b0;
        if (last) begin
            if (cur_pass) exp_pass = exp_pass + 1;
            else exp_drop = exp_drop + 1;
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({wData_Hdr_in_ready, wData_in_ready, wData_Hdr_out_valid, wData_out_valid, wData_out_last} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshakes got %b want 00000",
                     {wData_Hdr_in_ready, wData_in_ready, wData_Hdr_out_valid, wData_out_valid, wData_out_last});
        end
        total++;
        if ({bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength,
             bPass_packet_cnt, bDrop_packet_cnt} !== 128'd0) begin
            bad++;
            $display("[TB] FAIL reset_regs got ip=%h sp=%h len=%h pass=%0d drop=%0d want all 0",
                     bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength,
                     bPass_packet_cnt, bDrop_packet_cnt);
        end
        @(negedge wClk);
        wRst = 1'b1;
        @(posedge wClk);
        #1;
        total++;
        if (wData_Hdr_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_ready got %b want 1", wData_Hdr_in_ready);
        end
    endtask

    task automatic test_pass();
        int w;
        send_hdr(32'hC0A8_0001, 16'd1234, 16'd8080, 16'd40);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, w);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h00FF, 1'b1, w);
        total++;
        if (bPass_packet_cnt !== exp_pass || bDrop_packet_cnt !== exp_drop || exp_pass !== 32'd1) begin
            bad++;
            $display("[TB] FAIL pass_count got pass=%0d drop=%0d want %0d %0d",
                     bPass_packet_cnt, bDrop_packet_cnt, exp_pass, exp_drop);
        end
    endtask

    task automatic test_drop_port();
        int w;
        send_hdr(32'h0A00_0002, 16'd5555, 16'd53, 16'd40);
        for (int i = 0; i < 3; i++) begin
            send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, (i == 2), w);
            total++;
            if (w != 0) begin
                bad++;
                $display("[TB] FAIL drop_ready beat=%0d got waits=%0d want 0", i, w);
            end
        end
        total++;
        if (bDrop_packet_cnt !== exp_drop || bPass_packet_cnt !== exp_pass) begin
            bad++;
            $display("[TB] FAIL drop_count got pass=%0d drop=%0d want %0d %0d",
                     bPass_packet_cnt, bDrop_packet_cnt, exp_pass, exp_drop);
        end
    endtask

    task automatic test_drop_short();
        int w;
        send_hdr(32'h0A00_0003, 16'd7777, 16'd8080, 16'd4);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h000F, 1'b0, w);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h000F, 1'b1, w);
        total++;
        if (bDrop_packet_cnt !== exp_drop || bPass_packet_cnt !== exp_pass || exp_drop !== 32'd2) begin
            bad++;
            $display("[TB] FAIL short_count got pass=%0d drop=%0d want %0d %0d",
                     bPass_packet_cnt, bDrop_packet_cnt, exp_pass, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        int w;
        hdr_t want;
        want = {32'hDEAD_BEEF, 16'd4321, 16'd100};
        wData_Hdr_out_ready = 1'b0;
        send_hdr(want.ip, want.sp, 16'd8080, want.len);
        for (int i = 0; i < 5; i++) begin
            @(negedge wClk);
            total++;
            if (wData_Hdr_out_valid !== 1'b1 || wData_in_ready !== 1'b0 ||
                {bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength} !== want) begin
                bad++;
                $display("[TB] FAIL hdr_hold cyc=%0d got valid=%b rdy=%b fields=%h want 1 0 %h", i,
                         wData_Hdr_out_valid, wData_in_ready,
                         {bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength}, want);
            end
        end
        @(posedge wClk);
        #1;
        wData_Hdr_out_ready = 1'b1;
        out_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send_beat({$urandom, $urandom, $urandom, $urandom}, 16'(16'h1 << i), (i == 3), w);
        end
        out_mode = 0;
        total++;
        if (bPass_packet_cnt !== exp_pass || beat_q.size() != 0 || hdr_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL bp_result got pass=%0d beats_left=%0d hdrs_left=%0d want %0d 0 0",
                     bPass_packet_cnt, beat_q.size(), hdr_q.size(), exp_pass);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        send_hdr(32'h0101_0101, 16'd999, 16'd8080, 16'd64);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, w);
        wData_in_valid = 1'b1;
        bData_in_data = {$urandom, $urandom, $urandom, $urandom};
        wData_in_last = 1'b1;
        #2;
        wRst = 1'b0;
        #1;
        total++;
        if ({wData_Hdr_in_ready, wData_in_ready, wData_Hdr_out_valid, wData_out_valid, wData_out_last} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs got %b want 00000",
                     {wData_Hdr_in_ready, wData_in_ready, wData_Hdr_out_valid, wData_out_valid, wData_out_last});
        end
        total++;
        if (bPass_packet_cnt !== 32'd0 || bDrop_packet_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_counts got pass=%0d drop=%0d want 0 0",
                     bPass_packet_cnt, bDrop_packet_cnt);
        end
        exp_pass = 0;
        exp_drop = 0;
        beat_q.delete();
        hdr_q.delete();
        wData_in_valid = 1'b0;
        wData_in_last = 1'b0;
        @(negedge wClk);
        wRst = 1'b1;
        @(posedge wClk);
        #1;
        send_hdr(32'h0202_0202, 16'd1000, 16'd8080, 16'd8);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h0001, 1'b1, w);
        total++;
        if (bPass_packet_cnt !== 32'd1 || bDrop_packet_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL after_reset_count got pass=%0d drop=%0d want 1 0",
                     bPass_packet_cnt, bDrop_packet_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] p0;
        logic [31:0] d0;
        p0 = exp_pass;
        d0 = exp_drop;
        send_hdr(32'h0303_0303, 16'd11, 16'd8080, 16'd8);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, w);
        send_hdr(32'h0404_0404, 16'd22, 16'd8080, 16'd7);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, w);
        send_hdr(32'h0505_0505, 16'd33, 16'd8080, 16'd1500);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h7FFF, 1'b1, w);
        total++;
        if (bPass_packet_cnt !== p0 + 32'd2 || bDrop_packet_cnt !== d0 + 32'd1) begin
            bad++;
            $display("[TB] FAIL b2b_counts got pass=%0d drop=%0d want %0d %0d",
                     bPass_packet_cnt, bDrop_packet_cnt, p0 + 32'd2, d0 + 32'd1);
        end
    endtask

    initial begin
        hdr_t  eh;
        beat_t eb;
        fork
            forever begin
                @(negedge wClk);
                if (wData_Hdr_out_valid && wData_Hdr_out_ready) begin
                    total++;
                    if (hdr_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL hdr_unexpected got ip=%h want no header", bData_Hdr_out_IPSrcIpAddr);
                    end else begin
                        eh = hdr_q.pop_front();
                        if ({bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength} !== eh) begin
                            bad++;
                            $display("[TB] FAIL hdr_fields got %h want %h",
                                     {bData_Hdr_out_IPSrcIpAddr, bData_Hdr_out_UDPSrcPort, bData_Hdr_out_UDPLength}, eh);
                        end
                    end
                end
                if (wData_out_valid && wData_out_ready) begin
                    total++;
                    if (beat_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL beat_unexpected got data=%h want no beat", bData_out_data);
                    end else begin
                        eb = beat_q.pop_front();
                        if ({bData_out_data, bData_out_keep, wData_out_last} !== eb) begin
                            bad++;
                            $display("[TB] FAIL beat_data got %h want %h",
                                     {bData_out_data, bData_out_keep, wData_out_last}, eb);
                        end
                    end
                end
            end
            begin
                #2000000;
                $display("[TB] FAIL watchdog got timeout want completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        test_reset();
        test_pass();
        test_drop_port();
        test_drop_short();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge wClk);
        total++;
        if (hdr_q.size() != 0 || beat_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got hdrs=%0d beats=%0d want 0 0", hdr_q.size(), beat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
